// File: rtl/line_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_buffer_pkg : shared constants and pixel type for the 13-row line buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
package line_buffer_pkg;

    localparam int KERNEL = 13;
    localparam int PIX_W  = 8;
    localparam int LINES  = KERNEL - 1;

    typedef logic [PIX_W-1:0] pix_t;

endpackage : line_buffer_pkg
`default_nettype wire

// File: rtl/line_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_delay : enable-gated delay line, q = the d sample DEPTH enables earlier
// Revision: 1.0
// ---------------------------------------------------------------------------
module line_delay
    import line_buffer_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] q
);

    // The registered output holds one of the DEPTH samples in flight, so the
    // circular RAM itself needs only DEPTH-1 entries.
    localparam int RAM_D = DEPTH - 1;
    localparam int AW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam logic [AW-1:0] c_PTR_LAST = AW'(RAM_D - 1);

    pix_t          r_mem [0:RAM_D-1];
    logic [AW-1:0] r_ptr;
    pix_t          r_q;

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_q   <= '0;
        end else if (en) begin
            r_q   <= r_mem[r_ptr];
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign q = r_q;

endmodule : line_delay
`default_nettype wire

// File: rtl/line_buffer_13rows.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_buffer_13rows : raster pixel stream to 13-tall vertical pixel columns
// Revision: 1.0
// ---------------------------------------------------------------------------
module line_buffer_13rows
    import line_buffer_pkg::*;
#(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_i,
    input  logic [PIX_W-1:0] data_i,
    output logic [PIX_W-1:0] S1_o,
    output logic [PIX_W-1:0] S2_o,
    output logic [PIX_W-1:0] S3_o,
    output logic [PIX_W-1:0] S4_o,
    output logic [PIX_W-1:0] S5_o,
    output logic [PIX_W-1:0] S6_o,
    output logic [PIX_W-1:0] S7_o,
    output logic [PIX_W-1:0] S8_o,
    output logic [PIX_W-1:0] S9_o,
    output logic [PIX_W-1:0] S10_o,
    output logic [PIX_W-1:0] S11_o,
    output logic [PIX_W-1:0] S12_o,
    output logic [PIX_W-1:0] S13_o,
    output logic             done_o,
    output logic             progress_done_o
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] c_COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] c_ROW_FIRST = ROW_W'(LINES);

    logic [COL_W-1:0] r_col_cnt;
    logic [ROW_W-1:0] r_row_cnt;
    logic             r_done;
    logic             r_progress;
    pix_t             r_tap [1:KERNEL];
    pix_t             w_line_q [1:LINES];
    logic             w_col_last;
    logic             w_row_last;
    logic             w_qualify;

    assign w_col_last = (r_col_cnt == c_COL_LAST);
    assign w_row_last = (r_row_cnt == c_ROW_LAST);
    assign w_qualify  = (r_row_cnt >= c_ROW_FIRST);

    // L12 takes the live pixel; each line feeds the next-older one.
    for (genvar k = 1; k <= LINES; k++) begin : g_lines
        pix_t w_d;
        if (k == LINES) begin : g_head
            assign w_d = data_i;
        end else begin : g_link
            assign w_d = w_line_q[k+1];
        end
        line_delay #(
            .DEPTH (COLS)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .en  (done_i),
            .d   (w_d),
            .q   (w_line_q[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (done_i) begin
            if (w_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= KERNEL; k++) begin
                r_tap[k] <= '0;
            end
        end else if (done_i) begin
            r_tap[KERNEL] <= data_i;
            for (int k = 1; k <= LINES; k++) begin
                r_tap[k] <= w_line_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_progress <= 1'b0;
        end else begin
            r_done     <= done_i & w_qualify;
            r_progress <= done_i & w_row_last & w_col_last;
        end
    end

    assign S1_o            = r_tap[1];
    assign S2_o            = r_tap[2];
    assign S3_o            = r_tap[3];
    assign S4_o            = r_tap[4];
    assign S5_o            = r_tap[5];
    assign S6_o            = r_tap[6];
    assign S7_o            = r_tap[7];
    assign S8_o            = r_tap[8];
    assign S9_o            = r_tap[9];
    assign S10_o           = r_tap[10];
    assign S11_o           = r_tap[11];
    assign S12_o           = r_tap[12];
    assign S13_o           = r_tap[13];
    assign done_o          = r_done;
    assign progress_done_o = r_progress;

endmodule : line_buffer_13rows
`default_nettype wire

// File: tb/tb_line_buffer_13rows.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_line_buffer_13rows : self-checking bench against a pixel-history model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_line_buffer_13rows;

    localparam int COLS  = 4;
    localparam int ROWS  = 14;
    localparam int FRAME = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst;
    logic       done_i;
    logic [7:0] data_i;
    logic [7:0] tap [1:13];
    logic       done_o;
    logic       progress_done_o;

    int n_checks = 0;
    int n_errors = 0;

    int hist[$];
    int fpos;
    int total_acc;
    int done_seen;
    int exp_tap [1:13];
    bit exp_valid;
    int prog_at[$];

    always #5 clk = ~clk;

    line_buffer_13rows #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .done_i          (done_i),
        .data_i          (data_i),
        .S1_o            (tap[1]),
        .S2_o            (tap[2]),
        .S3_o            (tap[3]),
        .S4_o            (tap[4]),
        .S5_o            (tap[5]),
        .S6_o            (tap[6]),
        .S7_o            (tap[7]),
        .S8_o            (tap[8]),
        .S9_o            (tap[9]),
        .S10_o           (tap[10]),
        .S11_o           (tap[11]),
        .S12_o           (tap[12]),
        .S13_o           (tap[13]),
        .done_o          (done_o),
        .progress_done_o (progress_done_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat_pixel();
        return 8'(16 * (fpos / COLS) + (fpos % COLS));
    endfunction

    // One clock: drive, let the edge pass, compare against the pixel history.
    task automatic step(input bit acc, input logic [7:0] val);
        bit exp_done;
        bit exp_prog;
        exp_done = 1'b0;
        exp_prog = 1'b0;
        done_i   = acc;
        data_i   = val;
        if (acc) begin
            hist.push_back(int'(val));
            exp_done  = (fpos / COLS) >= 12;
            exp_prog  = (fpos == FRAME - 1);
            fpos      = (fpos + 1) % FRAME;
            total_acc++;
            exp_valid = exp_done;
            if (exp_done) begin
                for (int k = 1; k <= 13; k++) begin
                    exp_tap[k] = hist[hist.size() - 1 - (13 - k) * COLS];
                end
            end
        end
        @(posedge clk);
        #1;
        check_val("done_o", 32'(done_o), 32'(exp_done));
        check_val("progress_done_o", 32'(progress_done_o), 32'(exp_prog));
        if (exp_valid) begin
            for (int k = 1; k <= 13; k++) begin
                check_val($sformatf("S%0d_o", k), 32'(tap[k]), 32'(exp_tap[k]));
            end
        end
        if (done_o === 1'b1) done_seen++;
        if (progress_done_o === 1'b1) prog_at.push_back(total_acc);
        while (hist.size() > 13 * COLS) void'(hist.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        done_i = 1'b1;
        data_i = 8'($urandom);
        rst    = 1'b0;
        #1;
        check_val("rst_done_o", 32'(done_o), 32'h0);
        check_val("rst_progress", 32'(progress_done_o), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            check_val($sformatf("rst_S%0d_o", k), 32'(tap[k]), 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        hist.delete();
        fpos      = 0;
        exp_valid = 1'b1;
        for (int k = 1; k <= 13; k++) exp_tap[k] = 0;
    endtask

    task automatic check_first_pulse(input string tag);
        if (done_o === 1'b1 && done_seen == 1) begin
            check_val({tag, "_first_S1"}, 32'(tap[1]), 32'h00);
            check_val({tag, "_first_S7"}, 32'(tap[7]), 32'h60);
            check_val({tag, "_first_S13"}, 32'(tap[13]), 32'hC0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        done_i    = 1'b0;
        data_i    = 8'h00;
        fpos      = 0;
        total_acc = 0;
        exp_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Continuous strobe, one frame
        do_reset();
        step(1'b0, 8'h00);
        done_seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, pat_pixel());
            check_first_pulse("s1");
            if (i == FRAME - 1) begin
                check_val("s1_last_S1", 32'(tap[1]), 32'h13);
                check_val("s1_last_S13", 32'(tap[13]), 32'hD3);
                check_val("s1_last_progress", 32'(progress_done_o), 32'h1);
            end
        end
        step(1'b0, 8'h00);
        check_val("s1_pulses", 32'(done_seen), 32'd8);

        // Strobe every third cycle, random data on idle cycles
        do_reset();
        done_seen = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i % 3 == 0) step(1'b1, pat_pixel());
            else            step(1'b0, 8'($urandom));
            check_first_pulse("s2");
        end
        check_val("s2_pulses", 32'(done_seen), 32'd8);

        // Two frames back-to-back
        do_reset();
        done_seen = 0;
        prog_at.delete();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, pat_pixel());
            if (i == FRAME + 12 * COLS - 1) begin
                check_val("s3_no_early_done", 32'(done_seen), 32'd8);
            end
            if (i == FRAME + 12 * COLS) begin
                check_val("s3_f2_first_S1", 32'(tap[1]), 32'h00);
                check_val("s3_f2_first_S13", 32'(tap[13]), 32'hC0);
            end
        end
        step(1'b0, 8'h00);
        check_val("s3_prog_count", 32'(prog_at.size()), 32'd2);
        if (prog_at.size() == 2) begin
            check_val("s3_prog_spacing", 32'(prog_at[1] - prog_at[0]), 32'(FRAME));
        end

        // Reset landing on pixel (12,2), then a fresh frame
        do_reset();
        for (int i = 0; i < 12 * COLS + 2; i++) step(1'b1, pat_pixel());
        do_reset();
        done_seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, pat_pixel());
            check_first_pulse("s4");
            if (i == 12 * COLS - 1) check_val("s4_no_early_done", 32'(done_seen), 32'd0);
        end
        check_val("s4_pulses", 32'(done_seen), 32'd8);

        // Random data with random gaps, two frames
        do_reset();
        done_seen = 0;
        for (int guard = 0; guard < 20 * FRAME && total_acc >= 0; guard++) begin
            if (fpos == 0 && guard > 0 && done_seen >= 16) break;
            if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
            else                           step(1'b1, 8'($urandom));
        end
        step(1'b0, 8'h00);
        check_val("s5_pulses", 32'(done_seen), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_line_buffer_13rows
`default_nettype wire
